csr_timer: RTL and testbench



---
 rtl/csr_timer.sv | 103 ++++++++++
 tb/tb_csr_timer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer.sv
// Constant timer (TID/TCFG/TVAL/TICLR) and 64-bit stable counter beside the CSR unit.
// Optional macro STABLE_COUNTER_EN builds the stable counter; otherwise stable_cnt_o is 0.
module csr_timer #(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re_i,
  input  logic [13:0] csr_rnum_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_we_i,
  input  logic [13:0] csr_wnum_i,
  input  logic [31:0] csr_wdata_i,
  output logic        timer_int_o,
  output logic [63:0] stable_cnt_o,
  output logic [31:0] counter_id_o
);

  localparam logic [13:0] CsrTid   = 14'h40;
  localparam logic [13:0] CsrTcfg  = 14'h41;
  localparam logic [13:0] CsrTval  = 14'h42;
  localparam logic [13:0] CsrTiclr = 14'h44;
  localparam logic [31:0] TvalIdle = 32'hFFFF_FFFF;

  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        pend_q, pend_d;

  logic wr_tid, wr_tcfg, wr_ticlr, expire;

  assign wr_tid   = csr_we_i && (csr_wnum_i == CsrTid);
  assign wr_tcfg  = csr_we_i && (csr_wnum_i == CsrTcfg);
  assign wr_ticlr = csr_we_i && (csr_wnum_i == CsrTiclr);
  assign expire   = tcfg_q[0] && (tval_q == 32'h0);

  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    pend_d = pend_q;
    if (wr_tid) tid_d = csr_wdata_i;
    if (wr_tcfg) tcfg_d = csr_wdata_i;
    // A TCFG write always reloads TVAL, even if it collides with an expiry.
    if (wr_tcfg) begin
      tval_d = {csr_wdata_i[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q == 32'h0) begin
        tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : TvalIdle;
      end else if (tval_q != TvalIdle) begin
        tval_d = tval_q - 32'd1;
      end
    end
    if (wr_ticlr && csr_wdata_i[0]) pend_d = 1'b0;
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q  <= TID_INIT;
      tcfg_q <= 32'h0;
      tval_q <= TvalIdle;
      pend_q <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    csr_rdata_o = 32'h0;
    if (csr_re_i) begin
      case (csr_rnum_i)
        CsrTid:  csr_rdata_o = tid_q;
        CsrTcfg: csr_rdata_o = tcfg_q;
        CsrTval: csr_rdata_o = tval_q;
        default: csr_rdata_o = 32'h0;
      endcase
    end
  end

  assign timer_int_o  = pend_q;
  assign counter_id_o = tid_q;

`ifdef STABLE_COUNTER_EN
  logic [63:0] stable_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt_q <= 64'h0;
    end else begin
      stable_cnt_q <= stable_cnt_q + 64'd1;
    end
  end

  assign stable_cnt_o = stable_cnt_q;
`else
  assign stable_cnt_o = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: expiry-schedule reference model plus randomized CSR traffic.
module tb_csr_timer;
  localparam logic [31:0] TidInit = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_re = 1'b0;
  logic [13:0] csr_rnum = 14'h0;
  logic [31:0] csr_rdata;
  logic        csr_we = 1'b0;
  logic [13:0] csr_wnum = 14'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        timer_int;
  logic [63:0] stable_cnt;
  logic [31:0] counter_id;

  csr_timer #(.TID_INIT(TidInit)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re_i    (csr_re),
    .csr_rnum_i  (csr_rnum),
    .csr_rdata_o (csr_rdata),
    .csr_we_i    (csr_we),
    .csr_wnum_i  (csr_wnum),
    .csr_wdata_i (csr_wdata),
    .timer_int_o (timer_int),
    .stable_cnt_o(stable_cnt),
    .counter_id_o(counter_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: TVAL is derived from the edge index of the last TCFG write.
  logic [31:0] m_tid = TidInit;
  logic [31:0] m_tcfg = 32'h0;
  logic        m_loaded = 1'b0;
  logic        m_pend = 1'b0;
  logic [63:0] m_cnt = 64'h0;
  int          cyc = 0;
  int          m_k = 0;

  function automatic logic [31:0] model_tval(input int t);
    longint base, d;
    if (!m_loaded) return 32'hFFFF_FFFF;
    base = longint'({m_tcfg[31:2], 2'b00});
    d    = longint'(t - m_k);
    if (!m_tcfg[0]) return 32'(base);
    if (m_tcfg[1]) return 32'(base - (d % (base + 1)));
    if (d <= base) return 32'(base - d);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_rdata(input logic re, input logic [13:0] num);
    if (!re) return 32'h0;
    case (num)
      14'h40:  return m_tid;
      14'h41:  return m_tcfg;
      14'h42:  return model_tval(cyc);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] model_cnt();
`ifdef STABLE_COUNTER_EN
    return m_cnt;
`else
    return 64'h0;
`endif
  endfunction

  task automatic tick(input logic we, input logic [13:0] wnum, input logic [31:0] wdata);
    logic exp;
    csr_we = we;
    csr_wnum = wnum;
    csr_wdata = wdata;
    @(posedge clk);
    exp = !reset && m_loaded && m_tcfg[0] && (model_tval(cyc) == 32'h0);
    cyc++;
    if (reset) begin
      m_tid = TidInit; m_tcfg = 32'h0; m_loaded = 1'b0; m_pend = 1'b0; m_cnt = 64'h0;
    end else begin
      m_cnt++;
      if (we && wnum == 14'h44 && wdata[0]) m_pend = 1'b0;
      if (exp) m_pend = 1'b1;
      if (we && wnum == 14'h40) m_tid = wdata;
      if (we && wnum == 14'h41) begin
        m_tcfg = wdata; m_k = cyc; m_loaded = 1'b1;
      end
    end
    #1;
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num);
    csr_re = 1'b1;
    csr_rnum = num;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    logic [13:0] nums [4];
    reset = 1'b1;
    tick(1'b0, 14'h0, 32'h0);
    tick(1'b0, 14'h0, 32'h0);
    reset = 1'b0;
    nums   = '{14'h40, 14'h41, 14'h42, 14'h44};
    exp_rd = '{TidInit, 32'h0, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      rd(nums[i]);
      checks++;
      if (csr_rdata !== exp_rd[i]) begin
        errors++;
        $display("FAIL reset_rd[%0h] got=%h exp=%h", nums[i], csr_rdata, exp_rd[i]);
      end
    end
    checks++;
    if (timer_int !== 1'b0) begin
      errors++; $display("FAIL reset_int got=%b exp=0", timer_int);
    end
    checks++;
    if (stable_cnt !== 64'h0) begin
      errors++; $display("FAIL reset_cnt got=%h exp=0", stable_cnt);
    end
    checks++;
    if (counter_id !== TidInit) begin
      errors++; $display("FAIL reset_tid got=%h exp=%h", counter_id, TidInit);
    end
  endtask

  task automatic test_oneshot();
    int w, rise;
    tick(1'b1, 14'h41, 32'h0000_0009);
    w = cyc;
    rise = -1;
    for (int i = 0; i < 30; i++) begin
      rd(14'h42);
      checks++;
      if (csr_rdata !== model_tval(cyc) || timer_int !== m_pend) begin
        errors++;
        $display("FAIL oneshot cyc=%0d tval=%h/%h int=%b/%b", cyc - w, csr_rdata,
                 model_tval(cyc), timer_int, m_pend);
      end
      if (timer_int === 1'b1 && rise < 0) rise = cyc - w;
      tick(1'b0, 14'h0, 32'h0);
    end
    checks++;
    if (rise !== 9) begin
      errors++; $display("FAIL oneshot_latency got=%0d exp=9", rise);
    end
    tick(1'b1, 14'h44, 32'h1);
    for (int i = 0; i < 20; i++) begin
      rd(14'h42);
      checks++;
      if (timer_int !== 1'b0 || csr_rdata !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL oneshot_done int=%b exp=0 tval=%h exp=ffffffff", timer_int, csr_rdata);
      end
      tick(1'b0, 14'h0, 32'h0);
    end
  endtask

  task automatic test_periodic();
    tick(1'b1, 14'h41, 32'h0000_000B);
    for (int i = 0; i < 45; i++) begin
      rd(14'h42);
      checks++;
      if (csr_rdata !== model_tval(cyc) || timer_int !== m_pend) begin
        errors++;
        $display("FAIL periodic i=%0d tval=%h/%h int=%b/%b", i, csr_rdata, model_tval(cyc),
                 timer_int, m_pend);
      end
      if (i == 13) tick(1'b1, 14'h44, 32'h1);
      else tick(1'b0, 14'h0, 32'h0);
    end
  endtask

  task automatic test_clear_collision();
    int n = 0;
    while (model_tval(cyc) == 32'h0 && n < 20) begin tick(1'b0, 14'h0, 32'h0); n++; end
    tick(1'b1, 14'h44, 32'h1);
    n = 0;
    while (model_tval(cyc) != 32'h0 && n < 20) begin tick(1'b0, 14'h0, 32'h0); n++; end
    tick(1'b1, 14'h44, 32'h1);
    checks++;
    if (timer_int !== 1'b1 || m_pend !== 1'b1) begin
      errors++; $display("FAIL clear_collision int=%b exp=1", timer_int);
    end
  endtask

  task automatic test_tcfg_collision();
    int n = 0;
    tick(1'b1, 14'h41, 32'h0000_000B);
    tick(1'b1, 14'h44, 32'h1);
    while (model_tval(cyc) != 32'h0 && n < 20) begin tick(1'b0, 14'h0, 32'h0); n++; end
    tick(1'b1, 14'h41, 32'h0000_0015);
    rd(14'h42);
    checks++;
    if (csr_rdata !== 32'd20 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL tcfg_collision tval=%h exp=00000014 int=%b exp=1", csr_rdata, timer_int);
    end
  endtask

  task automatic test_disabled();
    tick(1'b1, 14'h41, 32'h0000_0008);
    tick(1'b1, 14'h44, 32'h1);
    for (int i = 0; i < 100; i++) tick(1'b0, 14'h0, 32'h0);
    rd(14'h42);
    checks++;
    if (csr_rdata !== 32'd8 || timer_int !== 1'b0) begin
      errors++; $display("FAIL disabled tval=%h exp=8 int=%b exp=0", csr_rdata, timer_int);
    end
    tick(1'b1, 14'h42, 32'h0);
    rd(14'h42);
    checks++;
    if (csr_rdata !== 32'd8) begin
      errors++; $display("FAIL tval_write_ignored got=%h exp=8", csr_rdata);
    end
  endtask

  task automatic test_tid();
    logic [31:0] v;
    v = $urandom;
    tick(1'b1, 14'h40, v);
    rd(14'h40);
    checks++;
    if (csr_rdata !== v || counter_id !== v) begin
      errors++; $display("FAIL tid rd=%h id=%h exp=%h", csr_rdata, counter_id, v);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 14'h41, 32'h0000_000B);
    for (int i = 0; i < 12; i++) tick(1'b0, 14'h0, 32'h0);
    reset = 1'b1;
    tick(1'b0, 14'h0, 32'h0);
    reset = 1'b0;
    rd(14'h42);
    checks++;
    if (csr_rdata !== 32'hFFFF_FFFF || timer_int !== 1'b0 || counter_id !== TidInit) begin
      errors++;
      $display("FAIL reset_mid tval=%h int=%b id=%h exp=ffffffff/0/%h", csr_rdata, timer_int,
               counter_id, TidInit);
    end
    rd(14'h41);
    checks++;
    if (csr_rdata !== 32'h0 || stable_cnt !== 64'h0) begin
      errors++; $display("FAIL reset_mid_tcfg tcfg=%h cnt=%h exp=0/0", csr_rdata, stable_cnt);
    end
  endtask

  task automatic test_counter();
`ifdef STABLE_COUNTER_EN
    force dut.stable_cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.stable_cnt_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    tick(1'b0, 14'h0, 32'h0);
    tick(1'b0, 14'h0, 32'h0);
    checks++;
    if (stable_cnt !== 64'h0) begin
      errors++; $display("FAIL counter_wrap got=%h exp=0", stable_cnt);
    end
`else
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 14'h0, 32'h0);
      checks++;
      if (stable_cnt !== 64'h0) begin
        errors++; $display("FAIL counter_tied got=%h exp=0", stable_cnt);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [13:0] nums [6];
    logic [13:0] wn, rn;
    logic [31:0] wd;
    logic        we;
    nums = '{14'h40, 14'h41, 14'h42, 14'h43, 14'h44, 14'h100};
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 3) == 0);
      wn = nums[$urandom_range(0, 5)];
      wd = $urandom;
      if (wn == 14'h41) wd = {27'($urandom_range(0, 5)), 3'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) != 0) ? 2'($urandom_range(2, 3)) : 2'b00};
      tick(we, wn, wd);
      rn = nums[$urandom_range(0, 5)];
      csr_re = ($urandom_range(0, 4) != 0);
      csr_rnum = rn;
      #1;
      checks++;
      if (csr_rdata !== model_rdata(csr_re, rn) || timer_int !== m_pend ||
          counter_id !== m_tid || stable_cnt !== model_cnt()) begin
        errors++;
        $display("FAIL random i=%0d rd[%0h]=%h/%h int=%b/%b id=%h/%h cnt=%h/%h", i, rn,
                 csr_rdata, model_rdata(csr_re, rn), timer_int, m_pend, counter_id, m_tid,
                 stable_cnt, model_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_clear_collision();
    test_tcfg_collision();
    test_disabled();
    test_tid();
    test_reset_mid();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
